// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_ctrl slice.
// Default FIFO geometry plus the wrap-aware pointer increment.
package fifo_pkg;

  localparam int DEF_DATA_BITS   = 10;
  localparam int DEF_FIFO_LENGTH = 16;
  localparam int DEF_ADDR_BIT    = 4;
  localparam int DEF_CNT_BIT     = 5;

  // Wraps at len-1 so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned len);
    return (ptr == len - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: clocked write port, asynchronous read port, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int FIFO_LENGTH = DEF_FIFO_LENGTH,
  parameter int ADDR_BIT    = DEF_ADDR_BIT
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BIT-1:0]  waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BIT-1:0]  raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [FIFO_LENGTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous first-word-fall-through FIFO controller.
// Define FIFO_PROG_FLAGS_EN to get programmable almost_full/almost_empty thresholds.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int FIFO_LENGTH = DEF_FIFO_LENGTH,
  parameter int ADDR_BIT    = DEF_ADDR_BIT,
  parameter int CNT_BIT     = DEF_CNT_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 write,
  input  logic [DATA_BITS-1:0] input_data,
  input  logic                 read,
  output logic [DATA_BITS-1:0] output_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_BIT-1:0]   count,
  input  logic [CNT_BIT-1:0]   af_level,
  input  logic [CNT_BIT-1:0]   ae_level,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  logic [ADDR_BIT-1:0] wr_ptr, rd_ptr;
  logic [CNT_BIT-1:0]  cnt_q;
  logic                ovf_q, unf_q;
  logic                push_ok, pop_ok, mem_we;

  assign full  = (cnt_q == CNT_BIT'(FIFO_LENGTH));
  assign empty = (cnt_q == '0);

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push alongside a read.
  assign push_ok = write && (!full || read);
  assign pop_ok  = read && !empty;
  assign mem_we  = push_ok && !clear && !reset;

  fifo_mem #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_LENGTH(FIFO_LENGTH),
    .ADDR_BIT   (ADDR_BIT)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr),
    .wdata(input_data),
    .raddr(rd_ptr),
    .rdata(output_data)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ADDR_BIT'(ptr_inc(32'(wr_ptr), FIFO_LENGTH));
      if (pop_ok)  rd_ptr <= ADDR_BIT'(ptr_inc(32'(rd_ptr), FIFO_LENGTH));
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_BIT'(1);
        2'b01:   cnt_q <= cnt_q - CNT_BIT'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (write && full && !read) ovf_q <= 1'b1;
      // Read+write on empty is treated as a plain push, not an underflow.
      if (read && empty && !write) unf_q <= 1'b1;
    end
  end

  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef FIFO_PROG_FLAGS_EN
  assign almost_full  = (cnt_q >= af_level);
  assign almost_empty = (cnt_q <= ae_level);
`else
  logic unused_levels;
  assign unused_levels = ^{af_level, ae_level};
  assign almost_full   = full;
  assign almost_empty  = empty;
`endif

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL: DATA_BITS, default 10, width of one FIFO word.
REQ-002 SHALL: FIFO_LENGTH, default 16, entry count, any integer >= 2 (power of two not required).
REQ-003 SHALL: ADDR_BIT, default 4, pointer width, >= clog2(FIFO_LENGTH).
REQ-004 SHALL: CNT_BIT, default 5, occupancy width, >= clog2(FIFO_LENGTH+1).
REQ-005 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL: clear  in  1  synchronous flush.
REQ-008 SHALL: write  in  1  push request; input_data  in  DATA_BITS  push word.
REQ-009 SHALL: read  in  1  pop request; output_data  out  DATA_BITS  head word.
REQ-010 SHALL: full, empty  out  1 each  occupancy flags.
REQ-011 SHALL: count  out  CNT_BIT  current occupancy.
REQ-012 SHALL: af_level, ae_level  in  CNT_BIT each; almost_full, almost_empty  out  1 each.
REQ-013 SHALL: overflow, underflow  out  1 each  sticky error flags.

Function
REQ-014 SHALL: output_data show the head entry combinationally (first-word-fall-through); value undefined while empty.
REQ-015 SHALL: push accepted when write=1 and (full=0 or read=1); pop accepted when read=1 and empty=0.
REQ-016 SHALL: accepted push store input_data at write pointer; pointers wrap FIFO_LENGTH-1 -> 0.
REQ-017 SHALL: count +1 on push-only, -1 on pop-only, unchanged on both or neither; full = (count==FIFO_LENGTH), empty = (count==0), both combinational from registered count.
REQ-018 SHALL: full with write=1 and read=1 -> pop and push both occur, count stays FIFO_LENGTH, full stays 1.
REQ-019 SHALL: empty with write=1 and read=1 -> push only (no bypass), count becomes 1, output_data valid next cycle.
REQ-020 SHALL: write=1 rejected (full, read=0) set overflow; read=1 rejected (empty) set underflow; flags stay 1 until reset or clear; contents/pointers untouched.
REQ-021 SHALL: clear=1 zero pointers, count, overflow, underflow next edge, ignoring write/read that cycle; memory contents not cleared.
REQ-022 SHALL: priority reset > clear > read/write.

Reset
REQ-023 SHALL: reset=1 at an edge force pointers=0, count=0, overflow=0, underflow=0, regardless of in-flight traffic; memory not reset.
REQ-024 SHALL: after reset empty=1, full=0, count=0, almost_empty=1 (with macro), almost_full=0.

Configuration
REQ-025 SHALL: macro FIFO_PROG_FLAGS_EN defined -> almost_full = (count >= af_level), almost_empty = (count <= ae_level), both combinational.
REQ-026 SHALL: macro undefined -> almost_full tied to full, almost_empty tied to empty; af_level/ae_level ignored; no comparators built.

Structure
REQ-027 SHALL: shared package fifo_pkg hold default widths/depth constants and the pointer-increment-with-wrap function.
REQ-028 SHALL: storage in sub-module fifo_mem (write port clocked, read port asynchronous, DATA_BITS x FIFO_LENGTH, no reset); pointers, count, flags in fifo_ctrl.

Verification
REQ-029 SHALL: fill: reset, 16 pushes 0x001..0x010 -> full=1 after 16th, count=16; 17th push -> overflow=1, count unchanged.
REQ-030 SHALL: drain: from full, 16 pops -> output_data 0x001..0x010 in order, empty=1; extra pop -> underflow=1.
REQ-031 SHALL: simultaneous at full: write=1, read=1 with 0x3FF -> head advances, count stays 16, 0x3FF emerges 16 pops later; no overflow.
REQ-032 SHALL: simultaneous at empty: write=1, read=1 with 0x155 -> count=1, output_data=0x155, underflow=0.
REQ-033 SHALL: FIFO_LENGTH=5 wrap: 12 interleaved push/pop pairs -> order preserved across pointer wrap, count never exceeds 5.
REQ-034 SHALL: with FIFO_PROG_FLAGS_EN, af_level=12, ae_level=2: almost_full rises at count 12, almost_empty falls at count 3; mid-stream clear then reset each return all state to REQ-024 values.
